// File: rtl/hazard_irq_ctrl.sv
// hazard_irq_ctrl
//   Pipeline sequencing controller for the five-stage MIPS core. It sits beside
//   decode and decides each cycle whether to stall PC and IF/ID, flush IF/ID
//   and ID/EX, or admit an interrupt/exception entry into decode. It owns the
//   external interrupt synchroniser, the IDLE/PENDING/MASKED state and two
//   saturating performance counters.
//
// Ports
//   clk              core clock, rising edge
//   reset            asynchronous active-low reset
//   iID_Instruction  instruction in decode (IF/ID output)
//   iID_UsesRt       decode instruction reads rt
//   iID_IsJump       j/jal/jr/jalr in decode
//   iID_Exception    decode flagged undefined opcode/funct
//   iEX_MemRead      load in EX
//   iEX_RegAddress   destination register of EX instruction
//   iEX_BranchTaken  conditional branch in EX resolved taken
//   iIrq             asynchronous level interrupt request
//   iCountClear      synchronous clear of both counters
//   oStall           hold PC and IF/ID
//   oFlush_IFID      bubble into IF/ID at next edge
//   oFlush_IDEX      bubble into ID/EX at next edge
//   oInterrupt       to Control.Interrupt: decode replaced by entry
//   oIrqState        IDLE=0, PENDING=1, MASKED=2
//   oStallCount      load-use stall cycles, saturating
//   oFlushCount      cycles with any flush, saturating
module hazard_irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] iID_Instruction,
   input  logic        iID_UsesRt,
   input  logic        iID_IsJump,
   input  logic        iID_Exception,
   input  logic        iEX_MemRead,
   input  logic [4:0]  iEX_RegAddress,
   input  logic        iEX_BranchTaken,
   input  logic        iIrq,
   input  logic        iCountClear,
   output logic        oStall,
   output logic        oFlush_IFID,
   output logic        oFlush_IDEX,
   output logic        oInterrupt,
   output logic [1:0]  oIrqState,
   output logic [15:0] oStallCount,
   output logic [15:0] oFlushCount
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PENDING = 2'd1;
   localparam logic [1:0] MASKED  = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic        irq_s1;
   logic        irq_s2;
   logic        irq_prev;
   logic        id_bubble;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        lu;
   logic        rise;
   logic        adm;
   logic        ret;
   logic        unused_bits;

   always_comb begin
      rs          = iID_Instruction[25:21];
      rt          = iID_Instruction[20:16];
      unused_bits = ^iID_Instruction[15:6];
      rise        = irq_s2 & ~irq_prev;

      lu = iEX_MemRead && (iEX_RegAddress != 5'd0) &&
           ((iEX_RegAddress == rs) || (iID_UsesRt && (iEX_RegAddress == rt)));

      // Admission only when decode holds a real instruction and nothing of
      // higher priority (taken branch, load-use) claims the cycle.
      adm = ~iEX_BranchTaken & ~lu & ~id_bubble &
            (iID_Exception | (state == PENDING));

      // Return from handler: jr $26 actually leaving decode this cycle.
      ret = (iID_Instruction[31:26] == 6'd0) && (iID_Instruction[5:0] == 6'h08) &&
            (rs == 5'd26) && ~lu && ~iEX_BranchTaken && ~id_bubble;

      oStall      = ~iEX_BranchTaken & lu;
      oFlush_IDEX = iEX_BranchTaken | lu;
      oFlush_IFID = iEX_BranchTaken | (~lu & (adm | iID_IsJump));
      oInterrupt  = adm;
      oIrqState   = state;
      oStallCount = stall_count;
      oFlushCount = flush_count;
   end

   always_comb begin
      state_next = state;
      if (adm) begin
         // Exception admission masks from any state; interrupt admission
         // only happens from PENDING, so both land in MASKED.
         state_next = MASKED;
      end else begin
         case (state)
            IDLE:    if (rise) state_next = PENDING;
            MASKED:  if (ret)  state_next = IDLE;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         irq_s1      <= 1'b0;
         irq_s2      <= 1'b0;
         irq_prev    <= 1'b0;
         id_bubble   <= 1'b1;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state    <= state_next;
         irq_s1   <= iIrq;
         irq_s2   <= irq_s1;
         irq_prev <= irq_s2;

         if (oFlush_IFID)
            id_bubble <= 1'b1;
         else if (!oStall)
            id_bubble <= 1'b0;

         if (iCountClear) begin
            stall_count <= '0;
            flush_count <= '0;
         end else begin
            if (oStall && (stall_count != '1))
               stall_count <= stall_count + 16'd1;
            if ((oFlush_IFID || oFlush_IDEX) && (flush_count != '1))
               flush_count <= flush_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_irq_ctrl.sv
// tb_hazard_irq_ctrl
//   Self-checking bench for hazard_irq_ctrl: a combinational vector table,
//   directed multi-cycle sequences and a randomized run, all compared against
//   a behavioural reference model of the sequencing rules.
module tb_hazard_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        uses_rt;
   logic        is_jump;
   logic        exc;
   logic        memrd;
   logic [4:0]  exreg;
   logic        br;
   logic        irq;
   logic        clr;
   logic        stall;
   logic        fl_ifid;
   logic        fl_idex;
   logic        intr;
   logic [1:0]  irq_state;
   logic [15:0] scnt;
   logic [15:0] fcnt;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_state;
   bit m_bubble;
   int m_scnt;
   int m_fcnt;
   bit hist[$];   // sampled iIrq values, most recent first

   typedef struct {
      logic [31:0] instr;
      logic        uses_rt;
      logic        jump;
      logic        exc;
      logic        memrd;
      logic [4:0]  exreg;
      logic        br;
      logic        e_st;
      logic        e_fi;
      logic        e_fe;
      logic        e_it;
   } vec_t;

   vec_t vecs[12];

   localparam logic [31:0] ADD_R8 = 32'h0101_4820;  // add $9,$8,$1
   localparam logic [31:0] NOP_OP = 32'h0022_1820;  // add $3,$1,$2
   localparam logic [31:0] JR26   = 32'h0340_0008;

   always #10 clk = ~clk;

   hazard_irq_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .iID_Instruction (instr),
      .iID_UsesRt      (uses_rt),
      .iID_IsJump      (is_jump),
      .iID_Exception   (exc),
      .iEX_MemRead     (memrd),
      .iEX_RegAddress  (exreg),
      .iEX_BranchTaken (br),
      .iIrq            (irq),
      .iCountClear     (clr),
      .oStall          (stall),
      .oFlush_IFID     (fl_ifid),
      .oFlush_IDEX     (fl_idex),
      .oInterrupt      (intr),
      .oIrqState       (irq_state),
      .oStallCount     (scnt),
      .oFlushCount     (fcnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Decision for the current cycle, straight from the priority list.
   task automatic predict(output bit st, output bit fi, output bit fe, output bit it);
      bit hz;
      logic [4:0] f_rs, f_rt;
      f_rs = instr[25:21];
      f_rt = instr[20:16];
      hz = memrd && (exreg != 0) && ((exreg == f_rs) || (uses_rt && (exreg == f_rt)));
      st = 0; fi = 0; fe = 0; it = 0;
      if (br) begin
         fi = 1; fe = 1;
      end else if (hz) begin
         st = 1; fe = 1;
      end else if (!m_bubble && (exc || m_state == 1)) begin
         it = 1; fi = 1;
      end else if (is_jump) begin
         fi = 1;
      end
   endtask

   task automatic model_edge();
      bit st, fi, fe, it, rise, jr26;
      predict(st, fi, fe, it);
      rise = hist[1] && !hist[2];
      jr26 = (instr[31:26] == 0) && (instr[5:0] == 6'h08) && (instr[25:21] == 26);
      if (it)                                                   m_state = 2;
      else if (m_state == 0 && rise)                            m_state = 1;
      else if (m_state == 2 && jr26 && !st && !br && !m_bubble) m_state = 0;
      if (fi)       m_bubble = 1;
      else if (!st) m_bubble = 0;
      if (clr) begin
         m_scnt = 0;
         m_fcnt = 0;
      end else begin
         if (st && m_scnt < 65535)         m_scnt++;
         if ((fi || fe) && m_fcnt < 65535) m_fcnt++;
      end
      hist.push_front(irq);
      void'(hist.pop_back());
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_bubble = 1;
      m_scnt   = 0;
      m_fcnt   = 0;
      hist     = '{0, 0, 0};
   endtask

   task automatic check_all();
      bit st, fi, fe, it;
      predict(st, fi, fe, it);
      chk("stall", stall, st);
      chk("flush_ifid", fl_ifid, fi);
      chk("flush_idex", fl_idex, fe);
      chk("interrupt", intr, it);
      chk("irq_state", irq_state, m_state);
      chk("stall_count", scnt, m_scnt);
      chk("flush_count", fcnt, m_fcnt);
   endtask

   // Called at posedge+1 with inputs set; checks, advances model, returns at next posedge+1.
   task automatic step();
      #1;
      check_all();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr   = NOP_OP;
      uses_rt = 1;
      is_jump = 0;
      exc     = 0;
      memrd   = 0;
      exreg   = 0;
      br      = 0;
   endtask

   initial begin
      //              instr   rt jmp exc mrd exreg br   st fi fe it
      vecs[0]  = '{ADD_R8, 1, 0, 0, 1, 5'd8, 0,  1, 0, 1, 0};
      vecs[1]  = '{ADD_R8, 1, 0, 0, 1, 5'd0, 0,  0, 0, 0, 0};
      vecs[2]  = '{ADD_R8, 1, 0, 0, 1, 5'd1, 0,  1, 0, 1, 0};
      vecs[3]  = '{ADD_R8, 0, 0, 0, 1, 5'd1, 0,  0, 0, 0, 0};
      vecs[4]  = '{ADD_R8, 1, 0, 0, 0, 5'd8, 0,  0, 0, 0, 0};
      vecs[5]  = '{ADD_R8, 1, 0, 0, 1, 5'd8, 1,  0, 1, 1, 0};
      vecs[6]  = '{ADD_R8, 1, 1, 0, 0, 5'd8, 0,  0, 1, 0, 0};
      vecs[7]  = '{ADD_R8, 1, 1, 0, 1, 5'd8, 0,  1, 0, 1, 0};
      vecs[8]  = '{ADD_R8, 1, 0, 1, 0, 5'd0, 0,  0, 1, 0, 1};
      vecs[9]  = '{ADD_R8, 1, 0, 1, 1, 5'd8, 0,  1, 0, 1, 0};
      vecs[10] = '{ADD_R8, 1, 0, 1, 0, 5'd0, 1,  0, 1, 1, 0};
      vecs[11] = '{ADD_R8, 1, 1, 1, 0, 5'd0, 0,  0, 1, 0, 1};

      reset = 0;
      irq   = 0;
      clr   = 0;
      idle();
      model_reset();
      #5;
      check_all();
      chk("reset_interrupt", intr, 0);
      chk("reset_state", irq_state, 0);
      @(posedge clk);
      #1;
      reset = 1;
      step();                      // clears id_bubble

      // combinational table, state IDLE, id_bubble=0, no edge in between
      foreach (vecs[i]) begin
         instr = vecs[i].instr; uses_rt = vecs[i].uses_rt; is_jump = vecs[i].jump;
         exc = vecs[i].exc; memrd = vecs[i].memrd; exreg = vecs[i].exreg; br = vecs[i].br;
         #1;
         chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_st);
         chk($sformatf("vec%0d_fifid", i), fl_ifid, vecs[i].e_fi);
         chk($sformatf("vec%0d_fidex", i), fl_idex, vecs[i].e_fe);
         chk($sformatf("vec%0d_intr", i), intr, vecs[i].e_it);
      end
      idle();

      // load-use
      clr = 1; step(); clr = 0;
      instr = ADD_R8; memrd = 1; exreg = 8;
      #1; chk("lu_stall", stall, 1); chk("lu_flush_idex", fl_idex, 1);
      step();
      chk("lu_stall_count", scnt, 1);
      exreg = 0;
      #1; chk("lu_r0_stall", stall, 0);
      step();
      // branch beats load-use
      br = 1; exreg = 8;
      #1; chk("br_stall", stall, 0); chk("br_fifid", fl_ifid, 1); chk("br_fidex", fl_idex, 1);
      step();
      chk("br_stall_count", scnt, 1);
      chk("br_flush_count", fcnt, 2);
      idle(); step();

      // interrupt entry
      irq = 1; repeat (3) step(); irq = 0;
      chk("irq_pending", irq_state, 1);
      #1; chk("irq_intr", intr, 1); chk("irq_fifid", fl_ifid, 1);
      step();
      chk("irq_masked", irq_state, 2);
      irq = 1;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) irq = 0;
         #1; chk("masked_no_intr", intr, 0);
         step();
      end

      // return, first blocked by a load-use stall
      instr = JR26; uses_rt = 0; memrd = 1; exreg = 26;
      #1; chk("ret_stall", stall, 1);
      step();
      chk("ret_held", irq_state, 2);
      memrd = 0;
      step();
      chk("ret_idle", irq_state, 0);

      // bubble delays admission; exception in MASKED
      idle();
      irq = 1; step(); step(); is_jump = 1; step(); is_jump = 0; irq = 0;
      chk("bub_pending", irq_state, 1);
      #1; chk("bub_no_intr", intr, 0);
      step();
      #1; chk("bub_intr", intr, 1);
      step();
      chk("bub_masked", irq_state, 2);
      step();
      exc = 1;
      #1; chk("exc_intr", intr, 1);
      step();
      exc = 0;
      chk("exc_masked", irq_state, 2);

      // randomized run
      for (int n = 0; n < 3000; n++) begin
         instr   = ($urandom_range(5) == 0) ? JR26 : $urandom;
         uses_rt = $urandom_range(1);
         is_jump = ($urandom_range(5) == 0);
         exc     = ($urandom_range(19) == 0);
         memrd   = ($urandom_range(2) == 0);
         case ($urandom_range(3))
            0:       exreg = 0;
            1:       exreg = instr[25:21];
            2:       exreg = instr[20:16];
            default: exreg = 5'($urandom);
         endcase
         br  = ($urandom_range(7) == 0);
         clr = ($urandom_range(49) == 0);
         if ($urandom_range(5) == 0) irq = ~irq;
         step();
      end
      clr = 0;
      irq = 0;

      // asynchronous reset while PENDING
      idle();
      reset = 0;
      model_reset();
      @(posedge clk); #1;
      reset = 1;
      step();
      irq = 1; repeat (3) step(); irq = 0;
      chk("rst_pending", irq_state, 1);
      #1;
      reset = 0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_fifid", fl_ifid, 0);
      chk("rst_fidex", fl_idex, 0);
      chk("rst_intr", intr, 0);
      chk("rst_state", irq_state, 0);
      chk("rst_scnt", scnt, 0);
      chk("rst_fcnt", fcnt, 0);
      model_reset();
      @(posedge clk); #1;
      reset = 1;
      repeat (6) begin
         #1; chk("post_rst_no_intr", intr, 0);
         step();
      end

      // flush counter saturation
      clr = 1; step(); clr = 0;
      br = 1;
      repeat (65535) step();
      chk("fcnt_full", fcnt, 16'hFFFF);
      step();
      chk("fcnt_sat", fcnt, 16'hFFFF);
      br = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
